// File: rtl/op_amp_with_frac.sv
// op_amp_with_frac: non-inverting stage whose fixed-point output converges on GAIN*non_inv each slow tick,
// published as an IEEE-754 single and alongside the divided sample clock.
module op_amp_with_frac #(
    parameter int CLK_DIV = 1000,
    parameter int GAIN    = 2,
    parameter int FRAC    = 16,
    parameter int SHIFT   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] non_inv,
    output logic [31:0] square_out,
    output logic        clk_100k
);
    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = $clog2(HALF);
    localparam int VW   = 24 + FRAC;
    localparam int PW   = $clog2(VW);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            clk_q, clk_d, wrap, tick;
    logic [VW-1:0]   v_q, v_d, tgt;
    logic signed [VW:0] diff, raw, step;
    logic [PW-1:0]   msb;
    logic [VW-2:0]   norm;
    logic            rnd;
    logic [31:0]     fl_q, fl_d;

    always_comb begin
        wrap  = cnt_q == CW'(HALF - 1);
        tick  = wrap && !clk_q;
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        clk_d = clk_q ^ wrap;
        tgt   = VW'(32'(non_inv) * 32'(GAIN)) << FRAC;
        diff  = $signed({1'b0, tgt}) - $signed({1'b0, v_q});
        raw   = diff >>> SHIFT;
        // a vanishing step is forced to one LSB so v lands exactly on the target
        step  = (raw == '0 && diff != '0) ? {{VW{diff[VW]}}, 1'b1} : raw;
        v_d   = tick ? VW'($signed({1'b0, v_q}) + step) : v_q;
        msb   = '0;
        for (int i = 0; i < VW; i++)
            if (v_q[i]) msb = PW'(i);
        norm  = (VW-1)'(v_q << (PW'(VW - 1) - msb));
        rnd   = norm[VW-25] & (norm[VW-24] | (|norm[VW-26:0]));
        // adding the round bit to the whole word lets a mantissa carry bump the exponent
        fl_d  = (v_q == '0) ? '0 : {1'b0, 8'(127 - FRAC + int'(msb)), norm[VW-2 -: 23]} + 32'(rnd);
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
            v_q   <= '0;
            fl_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
            v_q   <= v_d;
            fl_q  <= fl_d;
        end
    end

    assign square_out = fl_q;
    assign clk_100k   = clk_q;
endmodule

// File: tb/tb_op_amp_with_frac.sv
// tb_op_amp_with_frac: randomized and directed bench for op_amp_with_frac, tracking every tick
// against an integer convergence model and an independent float encoder.
module tb_op_amp_with_frac;
    localparam int CD = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] non_inv = '0;
    logic [31:0] square_out;
    logic        clk_100k;

    int     checks = 0, passed = 0, fails = 0;
    longint vm = 0;
    logic   prev = 1'b0;

    op_amp_with_frac #(.CLK_DIV(CD), .GAIN(2), .FRAC(16), .SHIFT(2)) dut (
        .clk(clk), .reset_n(reset_n), .non_inv(non_inv),
        .square_out(square_out), .clk_100k(clk_100k)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fp(longint v);
        int p = 0;
        int sh;
        longint q, rem, half;
        if (v == 0) return 32'h0;
        for (int i = 0; i < 40; i++) if (v[i]) p = i;
        if (p > 23) begin
            sh   = p - 23;
            q    = v / (64'sd1 <<< sh);
            rem  = v - q * (64'sd1 <<< sh);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'sd1 <<< 24)) begin q = q / 2; p++; end
        end else q = v * (64'sd1 <<< (23 - p));
        return {1'b0, 8'(127 + p - 16), q[22:0]};
    endfunction

    function automatic logic [31:0] ifl(int x);
        int p = 0;
        int m;
        if (x == 0) return 32'h0;
        for (int i = 0; i < 31; i++) if ((x >> i) & 1) p = i;
        m = x << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic chk_le(string tag, logic [31:0] o, logic [31:0] lim);
        checks++;
        assert (o <= lim) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h exceeds %h", tag, o, lim);
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b1;
        repeat (10) step;
        chk("rst_square", square_out, 32'h0);
        chk("rst_clk", 32'(clk_100k), 32'h0);
        reset_n = 1'b0;
        vm = 0;
        prev = 1'b0;
    endtask

    task automatic run_ticks(int n, bit up, logic [31:0] fin, int stable_from);
        longint tg, d, s;
        int w;
        for (int t = 0; t < n; t++) begin
            w = 0;
            do begin prev = clk_100k; step; w++; end
            while (!(prev == 1'b0 && clk_100k == 1'b1) && w < 2 * CD);
            if (!(prev == 1'b0 && clk_100k == 1'b1)) begin
                checks++;
                fails++;
                $error("FAIL tick_wait: observed no clk_100k rise in %0d clks, expected one within %0d", w, CD);
                return;
            end
            tg = (longint'(non_inv) * 2) * 65536;
            d  = tg - vm;
            s  = d >>> 2;
            if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
            vm += s;
            step;
            prev = clk_100k;
            chk("track", square_out, fp(vm));
            if (up) chk_le("overshoot", square_out, fin);
            if (t >= stable_from) chk("stable", square_out, fin);
        end
    endtask

    task automatic run_value(logic [15:0] nv, logic [31:0] expv);
        non_inv = nv;
        do_reset;
        run_ticks(130, 1'b1, expv, 110);
        chk("final", square_out, expv);
    endtask

    initial begin
        int cnt;
        logic [15:0] r;
        do_reset;
        cnt = 0;
        while (clk_100k == 1'b0 && cnt < 100) begin step; cnt++; end
        chk("first_rise", 32'(cnt), 32'(CD / 2));
        cnt = 0;
        while (clk_100k == 1'b1 && cnt < 100) begin step; cnt++; end
        chk("high_time", 32'(cnt), 32'(CD / 2));
        cnt = 0;
        while (clk_100k == 1'b0 && cnt < 100) begin step; cnt++; end
        chk("low_time", 32'(cnt), 32'(CD / 2));

        run_value(16'd1, 32'h4000_0000);
        run_value(16'd100, 32'h4348_0000);
        run_value(16'd3, 32'h40C0_0000);
        run_value(16'd65535, 32'h47FF_FF00);
        run_value(16'd0, 32'h0000_0000);
        run_value(16'd2, ifl(4));
        run_value(16'd32768, ifl(65536));
        run_value(16'd65534, ifl(131068));
        for (int k = 0; k < 15; k++) begin
            r = 16'($urandom_range(1, 65535));
            run_value(r, ifl(2 * int'(r)));
        end

        non_inv = 16'd100;
        do_reset;
        run_ticks(130, 1'b1, 32'h4348_0000, 110);
        non_inv = 16'd3;
        run_ticks(130, 1'b0, 32'h40C0_0000, 110);

        non_inv = 16'd5000;
        do_reset;
        run_ticks(30, 1'b1, 32'h461C_4000, 1000);
        reset_n = 1'b1;
        step;
        chk("mid_rst_square", square_out, 32'h0);
        chk("mid_rst_clk", 32'(clk_100k), 32'h0);
        do_reset;
        run_ticks(130, 1'b1, 32'h461C_4000, 110);
        chk("resettle", square_out, 32'h461C_4000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/op_amp_with_frac.md
Name: op_amp_with_frac

Overview:
- Discrete-time behavioural model of a non-inverting op-amp stage.
- A fixed-point output "voltage" moves toward GAIN × non_inv, one step per slow sample tick, and settles exactly on that value.
- The settled (or in-flight) value is published as an IEEE-754 single-precision word.
- Sits between the 16-bit sample source and the float-domain phase-detection/measurement logic; also exports the derived 100 kHz sample clock.

Parameters:
- CLK_DIV, 1000: clk cycles per clk_100k period; must be even and ≥ 4; 100 MHz → 100 kHz.
- GAIN, 2: closed-loop integer gain, 1..255.
- FRAC, 16: fractional bits of the internal output accumulator.
- SHIFT, 2: loop-step attenuation; step = (target − v) >>> SHIFT.

Ports:
- clk, input, 1: system clock, 100 MHz nominal.
- reset_n, input, 1: synchronous, active-high reset. Asserted when 1 and sampled on the rising edge of clk; the name is kept for codebase compatibility.
- non_inv, input, 16: unsigned non-inverting input sample, integer units.
- square_out, output, 32: IEEE-754 single-precision representation of the current output value.
- clk_100k, output, 1: divided clock, 50% duty cycle, period CLK_DIV clk cycles.

Behaviour:
- Reset (reset_n = 1 at a clk edge):
  - Divider count = 0, clk_100k = 0.
  - Accumulator v = 0, square_out = 32'h0000_0000.
  - Reset mid-operation abandons convergence; the restart is from v = 0.
- Divider:
  - cnt counts 0..CLK_DIV/2−1 and wraps.
  - clk_100k toggles at the wrap, so the first rising edge occurs CLK_DIV/2 clks after reset release.
  - tick = one-clk internal pulse in the same cycle clk_100k goes 0→1.
- Accumulator:
  - v is unsigned, width 24+FRAC bits (40 by default).
  - target T = (non_inv × GAIN) << FRAC. non_inv is sampled on each tick; a change mid-run simply redirects convergence.
  - On tick: d = T − v (signed, 1 bit wider than v); s = d >>> SHIFT (arithmetic shift).
    - If s = 0 and d ≠ 0: s = sign(d) × 1 LSB.
    - v ← v + s.
  - Result: v reaches T exactly and then holds constant (d = 0 ⇒ no change). No overshoot, no limit cycle.
  - Worst case (non_inv = 65535, GAIN = 2) settles in ≤ 110 ticks (1.1 ms).
- Float conversion (registered; square_out updates one clk after v changes):
  - v = 0 → 32'h0000_0000.
  - Otherwise:
    - p = index of the most significant 1 in v.
    - exponent = 127 + p − FRAC.
    - mantissa = the 23 bits below the leading 1.
    - If p > 23: round to nearest, ties to even, using the guard bit and sticky OR of the remaining dropped bits.
    - If p ≤ 23: left-justify, exact.
  - Mantissa round carry-out increments the exponent and zeroes the mantissa.
  - Sign bit is always 0. Denormal, Inf and NaN are never produced; the exponent range is guaranteed by the widths.
- Between ticks square_out is stable. After settling, square_out is constant on every subsequent clk_100k edge until non_inv changes or reset is asserted.

Test Plan:
- Reset for 10 clks, then release → square_out = 0 and clk_100k = 0 during reset; first clk_100k rise 500 clks after release; period exactly 1000 clks, high for 500.
- non_inv = 1, GAIN = 2, run 2 ms → square_out settles to 32'h4000_0000 (2.0) and stays unchanged for ≥ 20 consecutive clk_100k edges.
- non_inv = 100 → 32'h4348_0000 (200.0); non_inv = 3 → 32'h40C0_0000 (6.0); each stable within 2 ms.
- non_inv = 65535 → 32'h47FF_FF00 (131070.0) within 2 ms; no overshoot (bench checks each intermediate value as float ≤ final).
- Sweep non_inv 1..65535, with reset before each value → every value stable ≥ 20 edges within 2 ms and equal to the exact float of 2·non_inv; non_inv = 0 gives 32'h0000_0000.
- Assert reset at tick 30 of a non_inv = 5000 run, release, run 2 ms → square_out returns to 0 in the cycle after reset and re-settles to 32'h461C_4000 (10000.0).
